// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Holds the FSM encoding, stage indices and the perf counter width.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    localparam int STG_F   = 0;
    localparam int STG_D   = 1;
    localparam int STG_E   = 2;
    localparam int STG_M   = 3;
    localparam int STG_W   = 4;
    localparam int NUM_STG = 5;

    localparam int PERF_W = 32;

endpackage

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running event counter: increments on i_en and wraps at 2^PERF_W.
// Synchronous active-high reset.
module perf_counter
    import pipeline_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              i_en,
    output logic [PERF_W-1:0] o_count
);

    logic [PERF_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (reset_i)
            r_count <= '0;
        else if (i_en)
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Arbitrates HALT > memBusy > DIV > mispredict > dataHazard and owns the perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_BITS   = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        dataHazard_i,
    input  logic        E_mispredict_i,
    input  logic        E_isDIV_i,
    input  logic        E_isEBREAK_i,
    input  logic        M_memBusy_i,
    input  logic        resume_i,
    output logic        F_stall_o,
    output logic        D_stall_o,
    output logic        E_stall_o,
    output logic        M_stall_o,
    output logic        D_flush_o,
    output logic        E_flush_o,
    output logic        divStart_o,
    output logic        halted_o,
    output logic [31:0] stallCycles_o,
    output logic [31:0] flushCount_o
);

    state_e              r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_div_done;
    logic                r_ebrk_done;

    state_e              w_next_state;
    logic [CNT_BITS-1:0] w_next_cnt;
    logic                w_next_div_done;
    logic                w_next_ebrk_done;
    logic [STG_M:0]      w_stall;
    logic                w_d_flush;
    logic                w_e_flush;
    logic                w_div_start;
    logic                w_halted;
    logic [PERF_W-1:0]   w_stall_cnt;
    logic [PERF_W-1:0]   w_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_div_done  <= 1'b0;
            r_ebrk_done <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_div_done  <= w_next_div_done;
            r_ebrk_done <= w_next_ebrk_done;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_cnt       = r_cnt;
        w_next_div_done  = r_div_done;
        w_next_ebrk_done = r_ebrk_done;
        w_stall          = '0;
        w_d_flush        = 1'b0;
        w_e_flush        = 1'b0;
        w_div_start      = 1'b0;
        w_halted         = 1'b0;

        if (reset_i) begin
            w_next_state = ST_RUN;
        end else if (r_state == ST_HALT) begin
            w_stall  = '1;
            w_halted = 1'b1;
            // The EBREAK is still sitting in E on resume; let it retire once.
            if (resume_i) begin
                w_next_state     = ST_RUN;
                w_next_ebrk_done = 1'b1;
            end
        end else if (M_memBusy_i) begin
            w_stall = '1;
        end else if (r_state == ST_DIV_WAIT) begin
            w_stall[STG_F] = 1'b1;
            w_stall[STG_D] = 1'b1;
            w_stall[STG_E] = 1'b1;
            w_next_cnt     = r_cnt - CNT_BITS'(1);
            if (r_cnt <= CNT_BITS'(1)) begin
                w_next_state    = ST_RUN;
                w_next_div_done = 1'b1;
            end
        end else if (E_isDIV_i && !r_div_done) begin
            w_div_start    = 1'b1;
            w_stall[STG_F] = 1'b1;
            w_stall[STG_D] = 1'b1;
            w_stall[STG_E] = 1'b1;
            // Start cycle plus the wait window plus the advance cycle totals DIV_CYCLES.
            if (DIV_CYCLES <= 2) begin
                w_next_div_done = 1'b1;
            end else begin
                w_next_state = ST_DIV_WAIT;
                w_next_cnt   = CNT_BITS'(DIV_CYCLES - 2);
            end
        end else begin
            if (E_isEBREAK_i && !r_ebrk_done)
                w_next_state = ST_HALT;
            if (E_mispredict_i) begin
                w_d_flush = 1'b1;
                w_e_flush = 1'b1;
            end else if (dataHazard_i) begin
                w_stall[STG_F] = 1'b1;
                w_stall[STG_D] = 1'b1;
                w_e_flush      = 1'b1;
            end
        end

        // Any E advance means a new instruction occupies E next cycle.
        if (!reset_i && !w_stall[STG_E]) begin
            w_next_div_done  = 1'b0;
            w_next_ebrk_done = 1'b0;
        end
    end

    perf_counter u_stall_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_en    (w_stall[STG_F]),
        .o_count (w_stall_cnt)
    );

    perf_counter u_flush_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .i_en    (w_d_flush),
        .o_count (w_flush_cnt)
    );

    assign F_stall_o     = w_stall[STG_F];
    assign D_stall_o     = w_stall[STG_D];
    assign E_stall_o     = w_stall[STG_E];
    assign M_stall_o     = w_stall[STG_M];
    assign D_flush_o     = w_d_flush;
    assign E_flush_o     = w_e_flush;
    assign divStart_o    = w_div_start;
    assign halted_o      = w_halted;
    assign stallCycles_o = reset_i ? '0 : w_stall_cnt;
    assign flushCount_o  = reset_i ? '0 : w_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed test-plan walk plus randomized traffic, checked against a
// cycle-budget reference model of the stall/flush rules.
module tb_pipeline_ctrl;

    localparam int DIV_CYCLES = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_i, dataHazard_i, E_mispredict_i, E_isDIV_i, E_isEBREAK_i, M_memBusy_i, resume_i;
    logic F_stall_o, D_stall_o, E_stall_o, M_stall_o, D_flush_o, E_flush_o, divStart_o, halted_o;
    logic [31:0] stallCycles_o, flushCount_o;

    pipeline_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_BITS(8)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .dataHazard_i   (dataHazard_i),
        .E_mispredict_i (E_mispredict_i),
        .E_isDIV_i      (E_isDIV_i),
        .E_isEBREAK_i   (E_isEBREAK_i),
        .M_memBusy_i    (M_memBusy_i),
        .resume_i       (resume_i),
        .F_stall_o      (F_stall_o),
        .D_stall_o      (D_stall_o),
        .E_stall_o      (E_stall_o),
        .M_stall_o      (M_stall_o),
        .D_flush_o      (D_flush_o),
        .E_flush_o      (E_flush_o),
        .divStart_o     (divStart_o),
        .halted_o       (halted_o),
        .stallCycles_o  (stallCycles_o),
        .flushCount_o   (flushCount_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: remaining DIV stall cycles, halt flags, event totals.
    bit          m_halt, m_ebrk_ret, m_div_done;
    int          m_div_left;
    logic [31:0] m_stalls, m_flushes;

    // Last observed DUT values, for directed occupancy measurements.
    logic g_ds, g_es, g_h;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_halt = 0; m_ebrk_ret = 0; m_div_done = 0; m_div_left = 0;
        m_stalls = '0; m_flushes = '0;
    endtask

    task automatic step(input logic rst, input logic hz, input logic mp, input logic dv,
                        input logic eb, input logic mb, input logic rs);
        logic f, d, e, m, df, ef, ds, h;
        reset_i = rst; dataHazard_i = hz; E_mispredict_i = mp; E_isDIV_i = dv;
        E_isEBREAK_i = eb; M_memBusy_i = mb; resume_i = rs;
        @(negedge clk);
        {f, d, e, m, df, ef, ds, h} = '0;
        if (!rst) begin
            if (m_halt)                  begin {f, d, e, m} = '1; h = 1; end
            else if (mb)                 {f, d, e, m} = '1;
            else if (m_div_left > 0)     {f, d, e} = '1;
            else if (dv && !m_div_done)  begin {f, d, e} = '1; ds = 1; end
            else if (mp)                 begin df = 1; ef = 1; end
            else if (hz)                 begin f = 1; d = 1; ef = 1; end
        end
        chk("ctl", {24'd0, F_stall_o, D_stall_o, E_stall_o, M_stall_o, D_flush_o, E_flush_o, divStart_o, halted_o},
                   {24'd0, f, d, e, m, df, ef, ds, h});
        chk("stallCycles", stallCycles_o, rst ? 32'd0 : m_stalls);
        chk("flushCount",  flushCount_o,  rst ? 32'd0 : m_flushes);
        g_ds = divStart_o; g_es = E_stall_o; g_h = halted_o;
        if (rst) model_reset();
        else begin
            m_stalls  = m_stalls + {31'd0, f};
            m_flushes = m_flushes + {31'd0, df};
            if (m_halt) begin
                if (rs) begin m_halt = 0; m_ebrk_ret = 1; end
            end else if (!mb) begin
                if (m_div_left > 0) begin
                    m_div_left--;
                    if (m_div_left == 0) m_div_done = 1;
                end else if (dv && !m_div_done) begin
                    m_div_left = DIV_CYCLES - 2;
                    if (m_div_left == 0) m_div_done = 1;
                end else if (eb && !m_ebrk_ret) begin
                    m_halt = 1;
                end
            end
            if (!e) begin m_div_done = 0; m_ebrk_ret = 0; end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask

    initial begin
        int starts, stalls, occ;
        logic [31:0] fc0;
        model_reset();
        #1;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 1);

        // 1: single hazard cycle
        step(0, 1, 0, 0, 0, 0, 0);
        idle();
        chk("t1_stallCycles", stallCycles_o, 32'd1);

        // 2: two back-to-back DIV windows
        for (int w = 0; w < 2; w++) begin
            starts = 0; stalls = 0;
            for (int i = 0; i < DIV_CYCLES; i++) begin
                step(0, 0, 0, 1, 0, 0, 0);
                starts += int'(g_ds); stalls += int'(g_es);
            end
            chk("t2_starts", starts, 1);
            chk("t2_estall", stalls, DIV_CYCLES - 1);
        end
        idle();

        // 3: mispredict overrides hazard
        fc0 = flushCount_o;
        step(0, 1, 1, 0, 0, 0, 0);
        idle();
        chk("t3_flushinc", flushCount_o - fc0, 32'd1);

        // 4: memBusy stretches a DIV by 5 cycles
        occ = 0;
        for (int i = 0; i < 21; i++) begin step(0, 0, 0, 1, 0, 0, 0); occ++; end
        for (int i = 0; i < 5; i++)  begin step(0, 0, 0, 1, 0, 1, 0); occ++; end
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, 1, 0, 0, 0); occ++;
            if (!g_es) break;
        end
        chk("t4_occupancy", occ, DIV_CYCLES + 5);
        idle();

        // 5: EBREAK halt and resume
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i < 20; i++) step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 1);
        chk("t5_halt20", g_h, 1'b1);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t5_halt21", g_h, 1'b0);
        idle();

        // 6: reset in the middle of a DIV
        for (int i = 0; i < 26; i++) step(0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        idle();
        chk("t6_nostart", g_ds, 1'b0);
        chk("t6_cnt", stallCycles_o, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
                 $urandom_range(9) == 0, $urandom_range(29) == 0, $urandom_range(5) == 0,
                 $urandom_range(4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline (F, D, E, M, W).
- Collects the decode data hazard, execute-stage branch/jump mispredict, the multi-cycle divider, memory-busy and EBREAK.
- Produces per-stage stall and flush controls, including D_stall_i, D_flush_i, E_stall_i and E_flush_i for the decode unit.
- Owns the divider occupancy counter, the debug-halt state and two 32-bit performance counters.

Parameters:
DIV_CYCLES, 32, total cycles a DIV/REM instruction occupies E; legal range 2..255.
CNT_BITS, 8, width of the divider occupancy counter.

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  synchronous, active-high reset
dataHazard_i  in  1  decode load-use/CSR hazard (decode unit dataHazard_o)
E_mispredict_i  in  1  E resolved PC differs from predicted PC (branch, JAL, JALR)
E_isDIV_i  in  1  valid DIV/REM instruction in E (DE_isDIV_o)
E_isEBREAK_i  in  1  valid EBREAK in E
M_memBusy_i  in  1  data memory not ready; M cannot complete
resume_i  in  1  debug resume request
F_stall_o  out  1  hold PC / fetch register
D_stall_o  out  1  hold FD→DE transfer
E_stall_o  out  1  hold DE register / execute
M_stall_o  out  1  hold EM register
D_flush_o  out  1  bubble FD register; suppress RAS update
E_flush_o  out  1  bubble DE register
divStart_o  out  1  one-cycle start pulse to divider
halted_o  out  1  core halted on EBREAK
stallCycles_o  out  32  count of cycles with F_stall_o=1
flushCount_o  out  32  count of mispredict flushes

Behaviour:
- FSM states: RUN, DIV_WAIT, HALT. Reset → RUN, occupancy counter=0, divDone=0, both perf counters=0. While reset_i=1 all outputs are 0.
- Output priority, highest first: HALT > M_memBusy_i > DIV > mispredict > dataHazard. All outputs are combinational from state and inputs.
- M_memBusy_i=1 (any state other than HALT): F/D/E/M stall=1, no flushes, FSM holds, DIV counter frozen.
- HALT: F/D/E/M stall=1, halted_o=1. resume_i=1 → RUN next cycle; stalls drop in the RUN cycle. EBREAK retires normally after resume.
- RUN with E_isEBREAK_i=1 and !M_memBusy_i → HALT next cycle. Stalls assert from the HALT cycle on.
- RUN with E_isDIV_i=1, divDone=0, !M_memBusy_i:
  - divStart_o=1, F/D/E stall=1.
  - Next state DIV_WAIT, counter=DIV_CYCLES-2.
- DIV_WAIT: F/D/E stall=1, counter decrements each non-memBusy cycle. At counter==0 → RUN with divDone=1.
- divDone=1 suppresses retrigger for one E-advance; it clears on any cycle with E_stall_o=0.
- Result: DIV occupies E exactly DIV_CYCLES cycles, and divStart_o pulses exactly once per DIV.
- RUN, mispredict (no higher-priority cause): D_flush_o=1, E_flush_o=1, F/D stall=0, for exactly one cycle. Mispredict overrides a simultaneous dataHazard_i.
- RUN, dataHazard_i only: F_stall_o=1, D_stall_o=1, E_flush_o=1 (bubble into E), E/M stall=0.
- stallCycles_o increments on every cycle with F_stall_o=1. flushCount_o increments on every cycle with D_flush_o=1. Both wrap at 2^32.
- Reset mid-DIV or mid-HALT returns to RUN in one cycle, with the counter and divDone cleared.

Decomposition:
- Shared package: FSM state encoding (RUN=2'd0, DIV_WAIT=2'd1, HALT=2'd2), stage index constants, and perf counter width 32.
- One natural sub-module: perf_counter (32-bit enable-increment counter with synchronous reset), instantiated twice.

Test Plan:
1. Reset, then dataHazard_i=1 for 1 cycle → F_stall_o=D_stall_o=E_flush_o=1 in that cycle only; stallCycles_o=1 afterwards.
2. E_isDIV_i=1 held with DIV_CYCLES=32 → divStart_o pulses once at cycle 0; E_stall_o=1 for cycles 0..30 and 0 at cycle 31. The next E_isDIV_i (new instruction) starts a fresh 32-cycle window.
3. E_mispredict_i=1 with dataHazard_i=1 in the same cycle → D_flush_o=E_flush_o=1, F_stall_o=0; flushCount_o increments by 1.
4. DIV running (counter=10), M_memBusy_i=1 for 5 cycles → all stages stall and the counter stays 10. Total E occupancy becomes 37 cycles.
5. E_isEBREAK_i=1 → halted_o=1 from the next cycle, all stalls=1. resume_i=1 at cycle 20 → halted_o=0 at cycle 21.
6. reset_i=1 asserted during DIV_WAIT with counter=5 → next cycle: state RUN, all outputs 0, counters 0, no stray divStart_o.
